// File: rtl/io_rx_writer_if.sv
// io_rx_writer_if
// Bundles the TDM serial input pins and the io_mem write / status outputs of
// io_rx_writer.
//   master : the receiver (takes bclk/fsync/sdata, drives writes and status)
//   slave  : the environment (drives the serial pins, observes the writes)
// Signals:
//   bclk, fsync, sdata       serial bit clock, frame sync, serial data
//   wr_en, wr_addr, wr_data  io_mem write strobe, address, sample
//   ready_bank               bank holding the last complete frame
//   frame_done               one-cycle pulse per completed frame
//   locked                   high while frames are being tracked
//   sync_err                 one-cycle pulse on a framing violation
interface io_rx_writer_if #(
  parameter int IO_WIDTH      = 24,
  parameter int IO_ADDR_WIDTH = 10
);
  logic                     bclk;
  logic                     fsync;
  logic                     sdata;
  logic                     wr_en;
  logic [IO_ADDR_WIDTH-1:0] wr_addr;
  logic [IO_WIDTH-1:0]      wr_data;
  logic                     ready_bank;
  logic                     frame_done;
  logic                     locked;
  logic                     sync_err;

  modport master (
    input  bclk, fsync, sdata,
    output wr_en, wr_addr, wr_data, ready_bank, frame_done, locked, sync_err
  );

  modport slave (
    output bclk, fsync, sdata,
    input  wr_en, wr_addr, wr_data, ready_bank, frame_done, locked, sync_err
  );
endinterface

// File: rtl/io_rx_writer.sv
// io_rx_writer
// Deserialises a TDM audio stream (one-bit-delayed frame sync, MSB first) and
// writes each slot's IO_WIDTH-bit sample into a double-banked io_mem. At every
// good frame boundary the filled bank is published on ready_bank and the
// banks swap.
// Ports:
//   clk      system clock, at least 4x the bclk frequency
//   reset_n  synchronous active-low reset
//   bus      io_rx_writer_if.master: serial pins in, io_mem writes and
//            status (ready_bank, frame_done, locked, sync_err) out
module io_rx_writer #(
  parameter int NUM_CHANNELS  = 8,
  parameter int IO_WIDTH      = 24,
  parameter int SLOT_WIDTH    = 32,
  parameter int IO_ADDR_WIDTH = 10,
  parameter int BASE_ADDR     = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  io_rx_writer_if.master bus
);
  localparam int SLOT_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int BIT_BITS  = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;

  localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(NUM_CHANNELS - 1);
  localparam logic [BIT_BITS-1:0]  LAST_BIT  = BIT_BITS'(SLOT_WIDTH - 1);
  localparam logic [BIT_BITS-1:0]  WORD_LAST = BIT_BITS'(IO_WIDTH - 1);
  localparam logic [BIT_BITS:0]    WORD_LEN  = (BIT_BITS + 1)'(IO_WIDTH);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  // Two-flop synchronizers, bit order {bclk, fsync, sdata}.
  logic [2:0] w_pins;
  logic [2:0] r_meta;
  logic [2:0] r_sync;
  logic       r_bclk_prev;

  logic [0:0]               r_state;
  logic [SLOT_BITS-1:0]     r_slot;
  logic [BIT_BITS-1:0]      r_bit_cnt;
  logic [IO_WIDTH-2:0]      r_shift;     // first IO_WIDTH-1 bits of the word
  logic                     r_fill_bank;
  logic                     r_wr_en;
  logic [IO_ADDR_WIDTH-1:0] r_wr_addr;
  logic [IO_WIDTH-1:0]      r_wr_data;
  logic                     r_ready_bank;
  logic                     r_frame_done;
  logic                     r_sync_err;

  logic                     w_edge;
  logic                     w_fsync;
  logic                     w_sdata;
  logic                     w_frame_end;
  logic [IO_WIDTH-1:0]      w_word;
  logic [IO_ADDR_WIDTH-1:0] w_addr;

  assign w_pins = {bus.bclk, bus.fsync, bus.sdata};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta      <= '0;
      r_sync      <= '0;
      r_bclk_prev <= 1'b0;
    end else begin
      r_meta      <= w_pins;
      r_sync      <= r_meta;
      r_bclk_prev <= r_sync[2];
    end
  end

  // fsync/sdata pass through the same depth as bclk, so on the edge cycle
  // they show the values that were stable around the pin's rising edge.
  assign w_edge      = r_sync[2] & ~r_bclk_prev;
  assign w_fsync     = r_sync[1];
  assign w_sdata     = r_sync[0];
  assign w_frame_end = (r_slot == LAST_SLOT) && (r_bit_cnt == LAST_BIT);
  assign w_word      = {r_shift, w_sdata};
  assign w_addr      = IO_ADDR_WIDTH'(BASE_ADDR)
                     + (r_fill_bank ? IO_ADDR_WIDTH'(NUM_CHANNELS) : IO_ADDR_WIDTH'(0))
                     + IO_ADDR_WIDTH'(r_slot);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= HUNT;
      r_slot       <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      // The first frame after reset fills bank 0; ready_bank stays 0 until
      // frame_done says bank 0 really holds a frame.
      r_fill_bank  <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_ready_bank <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      if (w_edge) begin
        case (r_state)
          HUNT: begin
            if (w_fsync) begin
              r_state   <= RECV;
              r_slot    <= '0;
              r_bit_cnt <= '0;
            end
          end
          RECV: begin
            if (w_fsync && !w_frame_end) begin
              // Early frame sync: drop the partial word, realign to slot 0.
              r_sync_err <= 1'b1;
              r_slot     <= '0;
              r_bit_cnt  <= '0;
            end else begin
              if ({1'b0, r_bit_cnt} < WORD_LEN) begin
                r_shift <= w_word[IO_WIDTH-2:0];
              end
              // Address uses the pre-toggle bank even on the frame's last edge.
              if (r_bit_cnt == WORD_LAST) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= w_addr;
                r_wr_data <= w_word;
              end
              if (r_bit_cnt == LAST_BIT) begin
                r_bit_cnt <= '0;
                r_slot    <= r_slot + SLOT_BITS'(1);
              end else begin
                r_bit_cnt <= r_bit_cnt + BIT_BITS'(1);
              end
              if (w_frame_end) begin
                r_slot <= '0;
                if (w_fsync) begin
                  r_frame_done <= 1'b1;
                  r_ready_bank <= r_fill_bank;
                  r_fill_bank  <= ~r_fill_bank;
                end else begin
                  r_sync_err <= 1'b1;
                  r_state    <= HUNT;
                end
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.ready_bank = r_ready_bank;
  assign bus.frame_done = r_frame_done;
  assign bus.locked     = (r_state == RECV);
  assign bus.sync_err   = r_sync_err;
endmodule

// File: tb/tb_io_rx_writer.sv
// tb_io_rx_writer
// Directed bench for io_rx_writer: drives TDM frames at bclk = clk/4 and checks
// io_mem writes, bank publishing, framing errors and mid-frame reset.
module tb_io_rx_writer;
  localparam int NCH = 8;
  localparam int IOW = 24;
  localparam int SW  = 32;
  localparam int AW  = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  io_rx_writer_if #(.IO_WIDTH(IOW), .IO_ADDR_WIDTH(AW)) bus_if ();

  io_rx_writer #(
    .NUM_CHANNELS (NCH),
    .IO_WIDTH     (IOW),
    .SLOT_WIDTH   (SW),
    .IO_ADDR_WIDTH(AW),
    .BASE_ADDR    (0)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Write / pulse monitor, sampled on the falling clk edge.
  logic [AW-1:0]  wq_addr[$];
  logic [IOW-1:0] wq_data[$];
  int fd_cnt = 0;
  int se_cnt = 0;
  int close_cnt = 0;
  int cyc = 0;
  int last_wr = -100;

  always @(negedge clk) begin
    cyc++;
    if (bus_if.wr_en === 1'b1) begin
      if (cyc - last_wr < 4) close_cnt++;
      last_wr = cyc;
      wq_addr.push_back(bus_if.wr_addr);
      wq_data.push_back(bus_if.wr_data);
    end
    if (bus_if.frame_done === 1'b1) fd_cnt++;
    if (bus_if.sync_err === 1'b1) se_cnt++;
  end

  logic [IOW-1:0] fw[NCH];
  logic [7:0]     ft[NCH];

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic send_bit(input logic d, input logic fs);
    bus_if.sdata = d;
    bus_if.fsync = fs;
    #20 bus_if.bclk = 1'b1;
    #20 bus_if.bclk = 1'b0;
  endtask

  // mode 0: full frame; 1: fsync at (ms,mb) and stop; 2: stop after (ms,mb).
  task automatic send_frame(input logic fs_end, input int mode, input int ms, input int mb);
    logic [31:0] sw;
    logic fs;
    for (int s = 0; s < NCH; s++) begin
      sw = {fw[s], ft[s]};
      for (int b = 0; b < SW; b++) begin
        if (s == NCH - 1 && b == SW - 1) fs = fs_end;
        else fs = (mode == 1 && s == ms && b == mb);
        send_bit(sw[31-b], fs);
        if (mode != 0 && s == ms && b == mb) return;
      end
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic check_writes(input string tag, input int bank, input int n);
    check({tag, " wr_count"}, 64'(wq_addr.size()), 64'(n));
    for (int i = 0; i < n && i < wq_addr.size(); i++)
      check($sformatf("%s wr%0d addr/data", tag, i),
            {30'd0, wq_addr[i], wq_data[i]}, {30'd0, AW'(bank * NCH + i), fw[i]});
  endtask

  task automatic set_words(input logic [IOW-1:0] base, input logic [7:0] tail);
    for (int c = 0; c < NCH; c++) begin
      fw[c] = base + IOW'(c);
      ft[c] = tail;
    end
  endtask

  initial begin
    int bank;
    int r;
    bus_if.bclk = 1'b0;
    bus_if.fsync = 1'b0;
    bus_if.sdata = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    check("reset outputs",
          {bus_if.wr_en, bus_if.frame_done, bus_if.locked, bus_if.sync_err,
           bus_if.ready_bank, bus_if.wr_addr, bus_if.wr_data}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #3;

    // Acquire lock
    send_bit(1'b0, 1'b1);
    #80;
    check("lock after fsync", bus_if.locked, 1);

    // Frame 1 -> bank 0
    set_words(24'h100000, 8'h00);
    clear_log();
    send_frame(1'b1, 0, 0, 0);
    #80;
    check_writes("frame1", 0, 8);
    check("frame1 frame_done count", fd_cnt, 1);
    check("frame1 ready_bank", bus_if.ready_bank, 0);

    // Frame 2 -> bank 1
    set_words(24'h800001, 8'h00);
    clear_log();
    send_frame(1'b1, 0, 0, 0);
    #80;
    check_writes("frame2", 1, 8);
    check("frame2 frame_done count", fd_cnt, 2);
    check("frame2 ready_bank", bus_if.ready_bank, 1);
    check("clean frames sync_err count", se_cnt, 0);

    // Trailing slot bits must be ignored
    set_words(24'hABC000, 8'hFF);
    fw[2] = 24'h7FFFFF;
    ft[2] = 8'hA5;
    clear_log();
    send_frame(1'b1, 0, 0, 0);
    #80;
    check_writes("trailing", 0, 8);
    check("trailing ready_bank", bus_if.ready_bank, 0);

    // Early fsync at slot 3 bit 10 (bank 1)
    set_words(24'h111110, 8'h00);
    clear_log();
    send_frame(1'b1, 1, 3, 10);
    #80;
    check_writes("early", 1, 3);
    check("early sync_err count", se_cnt, 1);
    check("early locked", bus_if.locked, 1);
    check("early frame_done count", fd_cnt, 3);

    // Next edge restarts at slot 0 bit 0, same bank
    set_words(24'h222220, 8'h00);
    clear_log();
    send_frame(1'b1, 0, 0, 0);
    #80;
    check_writes("after early", 1, 8);
    check("after early frame_done count", fd_cnt, 4);
    check("after early ready_bank", bus_if.ready_bank, 1);

    // Missing fsync at end of frame (bank 0)
    set_words(24'h333330, 8'h00);
    clear_log();
    send_frame(1'b0, 0, 0, 0);
    #80;
    check_writes("no fsync", 0, 8);
    check("no fsync sync_err count", se_cnt, 2);
    check("no fsync locked", bus_if.locked, 0);
    check("no fsync frame_done count", fd_cnt, 4);
    check("no fsync ready_bank", bus_if.ready_bank, 1);

    // Relock; bank 0 is refilled
    send_bit(1'b0, 1'b1);
    #80;
    check("relock locked", bus_if.locked, 1);
    set_words(24'h444440, 8'h00);
    clear_log();
    send_frame(1'b1, 0, 0, 0);
    #80;
    check_writes("relock", 0, 8);
    check("relock frame_done count", fd_cnt, 5);
    check("relock ready_bank", bus_if.ready_bank, 0);

    // Reset for one cycle at slot 5 bit 12 (bank 1)
    set_words(24'h666660, 8'h00);
    clear_log();
    send_frame(1'b1, 2, 5, 12);
    #80;
    check_writes("pre-reset", 1, 5);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midframe reset outputs",
          {bus_if.wr_en, bus_if.frame_done, bus_if.locked, bus_if.sync_err,
           bus_if.ready_bank, bus_if.wr_addr, bus_if.wr_data}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #3;
    #80;
    check("no slot5 write after reset", 64'(wq_addr.size()), 64'd5);
    send_bit(1'b0, 1'b1);
    #80;
    check("post-reset locked", bus_if.locked, 1);
    set_words(24'h555550, 8'h00);
    clear_log();
    send_frame(1'b1, 0, 0, 0);
    #80;
    check_writes("post-reset", 0, 8);
    check("post-reset frame_done count", fd_cnt, 6);

    // Random clk/bclk phase, back-to-back frames at exactly 4x
    bank = 1;
    for (int g = 0; g < 4; g++) begin
      @(posedge clk);
      r = $urandom_range(1, 8);
      if (r >= 5) r++;
      #(r);
      for (int f = 0; f < 6; f++) begin
        for (int c = 0; c < NCH; c++) begin
          fw[c] = IOW'($urandom);
          ft[c] = 8'($urandom);
        end
        clear_log();
        send_frame(1'b1, 0, 0, 0);
        check_writes($sformatf("rnd g%0d f%0d", g, f), bank, 8);
        bank ^= 1;
      end
      #80;
    end
    check("random frame_done count", fd_cnt, 30);
    check("random sync_err count", se_cnt, 2);
    check("random ready_bank", bus_if.ready_bank, 64'(bank ^ 1));
    check("writes closer than 4 clk", close_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
